// File: rtl/alu_op_defs.sv
// HI/LO op-code constants and datapath width shared by the ID decoder and the EX mul/div unit.
package alu_op_defs;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_hilo_op(input logic [5:0] op);
    return op inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative datapath: MSB-first shift-add multiply or restoring divide, one bit per step.
module md_iter_core #(
  parameter int XLEN = alu_op_defs::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   shift_src,
  input  logic [XLEN-1:0]   fixed_src,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sreg_q, sreg_d;
  logic [XLEN-1:0]   fixed_q, fixed_d;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     trial;

  // Divide keeps {remainder, quotient} in acc; sreg feeds multiplier/dividend bits MSB first.
  always_comb begin
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    fixed_d   = fixed_q;
    rem_shift = {acc_q[2*XLEN-1:XLEN], sreg_q[XLEN-1]};
    trial     = rem_shift - {1'b0, fixed_q};
    if (load) begin
      acc_d   = '0;
      sreg_d  = shift_src;
      fixed_d = fixed_src;
    end else if (step) begin
      sreg_d = {sreg_q[XLEN-2:0], 1'b0};
      if (is_div) begin
        if (!trial[XLEN])
          acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {acc_q[2*XLEN-2:0], 1'b0} +
                (sreg_q[XLEN-1] ? {{XLEN{1'b0}}, fixed_q} : {(2*XLEN){1'b0}});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      sreg_q  <= '0;
      fixed_q <= '0;
    end else begin
      acc_q   <= acc_d;
      sreg_q  <= sreg_d;
      fixed_q <= fixed_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: FSM, iteration counter, sign fix-up, HI/LO registers and hazard stall.
module ex_muldiv_unit #(
  parameter int XLEN  = alu_op_defs::XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_result,
  output logic            mf_valid
);
  import alu_op_defs::*;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_q_q, neg_q_d;   // quotient / product negate
  logic              neg_r_q, neg_r_d;   // remainder negate
  logic              div0_q, div0_d;

  logic              idle, hilo_op, accept_md, signed_op, div_op;
  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quot, rem;

  assign idle      = (state_q == ST_IDLE);
  assign hilo_op   = op_valid && is_hilo_op(alu_op);
  assign stall     = hilo_op && !idle;
  assign busy      = !idle;
  assign accept_md = hilo_op && idle && (alu_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign div_op    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign rs_neg    = signed_op && rs_data[XLEN-1];
  assign rt_neg    = signed_op && rt_data[XLEN-1];
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_md),
    .step      (state_q == ST_CALC),
    .is_div    (is_div_q),
    .shift_src (div_op ? rs_mag : rt_mag),
    .fixed_src (div_op ? rt_mag : rs_mag),
    .acc       (acc)
  );

  assign prod = neg_q_q ? -acc : acc;
  assign quot = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_md) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          is_div_d = div_op;
          neg_q_d  = rs_neg ^ rt_neg;
          neg_r_d  = rs_neg;
          div0_d   = div_op && (rt_data == '0);
        end else if (hilo_op && alu_op == OP_MTHI) begin
          hi_d = rs_data;
        end else if (hilo_op && alu_op == OP_MTLO) begin
          lo_d = rs_data;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) state_d = ST_FIX;
      end
      ST_FIX: begin
        // A zero divisor leaves the dividend magnitude as remainder, so HI already equals rs.
        if (is_div_q) begin
          lo_d = div0_q ? {XLEN{1'b1}} : (neg_q_q ? -quot : quot);
          hi_d = neg_r_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mf_valid  = hilo_op && idle && (alu_op == OP_MFHI || alu_op == OP_MFLO);
  assign mf_result = mf_valid ? ((alu_op == OP_MFHI) ? hi_q : lo_q) : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADD  = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [5:0]  alu_op;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy, mf_valid;
  logic [31:0] hi, lo, mf_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .alu_op    (alu_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .mf_result (mf_result),
    .mf_valid  (mf_valid)
  );

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    alu_op   = op;
    rs_data  = a;
    rt_data  = b;
  endtask

  // Reference: HI/LO from full-width arithmetic on the architectural operands.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (op)
      MULTU: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      MULT:  begin p = sa * sb;                 eh = p[63:32]; el = p[31:0]; end
      DIVU: begin
        if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      DIV: begin
        if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int cnt;
    model(op, a, b, eh, el);
    drive(1'b1, op, a, b);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL issue_stall op=%h got=%b exp=0", op, stall); end
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    checks++;
    if (cnt != 33) begin errors++; $display("FAIL busy_cycles op=%h got=%0d exp=33", op, cnt); end
    checks++;
    if (hi !== eh) begin errors++; $display("FAIL hi op=%h a=%h b=%h got=%h exp=%h", op, a, b, hi, eh); end
    checks++;
    if (lo !== el) begin errors++; $display("FAIL lo op=%h a=%h b=%h got=%h exp=%h", op, a, b, lo, el); end
    hi_m = eh;
    lo_m = el;
    $display("md op=%h a=%h b=%h -> hi=%h lo=%h busy=%0d", op, a, b, hi, lo, cnt);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 6'h00, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, stall, mf_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {busy, stall, mf_valid});
    end
    checks++;
    if ({hi, lo, mf_result} !== 96'h0) begin
      errors++; $display("FAIL reset_regs hi=%h lo=%h mf=%h exp=0", hi, lo, mf_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, MFLO, '0, '0);
    @(negedge clk);
    checks++;
    if (mf_valid !== 1'b1 || mf_result !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_mflo valid=%b res=%h stall=%b exp=1/0/0", mf_valid, mf_result, stall);
    end
    $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);
  endtask

  task automatic test_directed();
    run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_md(MULT,  32'hFFFFFFFD, 32'd7);
    run_md(DIV,   32'hFFFFFFF9, 32'd2);
    run_md(DIVU,  32'd5,        32'd0);
    run_md(DIV,   32'h80000000, 32'hFFFFFFFF);
    run_md(DIV,   32'hFFFFFFFB, 32'd0);
    run_md(MULT,  32'h80000000, 32'h80000000);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 24; n++) begin
      op = 6'h18 + 6'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_md(op, a, b);
    end
  endtask

  task automatic test_mt_mf();
    logic [31:0] v1, v2;
    for (int n = 0; n < 4; n++) begin
      v1 = $urandom;
      v2 = $urandom;
      drive(1'b1, MTHI, v1, $urandom);
      @(posedge clk); #1;
      drive(1'b1, MTLO, v2, $urandom);
      @(posedge clk); #1;
      hi_m = v1;
      lo_m = v2;
      drive(1'b1, MFHI, $urandom, $urandom);
      @(negedge clk);
      checks++;
      if (mf_valid !== 1'b1 || mf_result !== hi_m) begin
        errors++; $display("FAIL mfhi valid=%b got=%h exp=%h", mf_valid, mf_result, hi_m);
      end
      @(posedge clk); #1;
      drive(1'b1, MFLO, $urandom, $urandom);
      @(negedge clk);
      checks++;
      if (mf_valid !== 1'b1 || mf_result !== lo_m) begin
        errors++; $display("FAIL mflo valid=%b got=%h exp=%h", mf_valid, mf_result, lo_m);
      end
      $display("mt/mf: hi=%h lo=%h", hi, lo);
      @(posedge clk); #1;
    end
    drive(1'b0, 6'h00, '0, '0);
  endtask

  task automatic test_dependent();
    drive(1'b1, MULTU, 32'd6, 32'd7);
    @(posedge clk); #1;
    drive(1'b1, MFLO, '0, '0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mf_valid !== 1'b0) begin
        errors++; $display("FAIL dep_stall cycle=N+%0d stall=%b mf_valid=%b exp=1/0", c, stall, mf_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mf_valid !== 1'b1 || mf_result !== 32'd42) begin
      errors++; $display("FAIL dep_release stall=%b valid=%b res=%h exp=0/1/2a", stall, mf_valid, mf_result);
    end
    hi_m = 32'h0;
    lo_m = 32'd42;
    $display("dependent mflo: stall=%b mf_valid=%b mf_result=%h", stall, mf_valid, mf_result);
    @(posedge clk); #1;
    drive(1'b0, 6'h00, '0, '0);
  endtask

  task automatic test_unrelated();
    int seen;
    drive(1'b1, MULTU, 32'd3, 32'd4);
    @(posedge clk); #1;
    seen = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 17) drive(1'b0, MTLO, $urandom, $urandom);
      else drive(1'b1, ADD, $urandom, $urandom);
      @(negedge clk);
      if (stall !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL unrelated_stall got=%0d exp=0", seen); end
    drive(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin
      errors++; $display("FAIL unrelated_result busy=%b hi=%h lo=%h exp=0/0/c", busy, hi, lo);
    end
    hi_m = 32'h0;
    lo_m = 32'd12;
    $display("unrelated: hi=%h lo=%h", hi, lo);
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    drive(1'b1, MTHI, 32'h12345678, '0);
    @(posedge clk); #1;
    drive(1'b1, MTLO, 32'hA5A5A5A5, '0);
    @(posedge clk); #1;
    drive(1'b1, MULTU, 32'hDEADBEEF, 32'd3);
    @(posedge clk); #1;
    drive(1'b1, MFLO, '0, '0);
    repeat (9) @(posedge clk);
    #2;
    checks++;
    if (stall !== 1'b1 || hi !== 32'h12345678) begin
      errors++; $display("FAIL pre_rst stall=%b hi=%h exp=1/12345678", stall, hi);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, stall} !== 2'b00 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL rst_mid busy=%b stall=%b hi=%h lo=%h exp=0", busy, stall, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mf_valid !== 1'b1 || mf_result !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL post_rst_mflo valid=%b res=%h stall=%b exp=1/0/0", mf_valid, mf_result, stall);
    end
    drive(1'b0, 6'h00, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lo !== 32'h0) begin
      errors++; $display("FAIL post_rst_idle busy=%b lo=%h exp=0/0", busy, lo);
    end
    hi_m = '0;
    lo_m = '0;
    $display("rst mid-op: busy=%b hi=%h lo=%h", busy, hi, lo);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt_mf();
    test_dependent();
    test_unrelated();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage that consumes the ALU-op, operand and valid outputs of the ID/EX pipeline latch. It implements the MIPS HI/LO instructions:

- MULT, MULTU, DIV, DIVU start a multi-cycle operation.
- MFHI, MFLO read HI/LO.
- MTHI, MTLO write HI/LO.

It drives `stall` back to the hazard/latch-enable logic so that a dependent instruction freezes IF/ID and ID/EX until HI/LO are valid.

## Interface
Parameters:
- `XLEN`, 32, operand and HI/LO width.
- `CNT_W`, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op_valid`  in  1  an instruction is present in EX (ID/EX latch output is not a bubble).
- `alu_op`  in  6  function code from the ID/EX latch.
- `rs_data`  in  XLEN  first operand (data1 from ID/EX).
- `rt_data`  in  XLEN  second operand (data2 from ID/EX).
- `stall`  out  1  hold IF/ID and ID/EX, and insert a bubble into EX/MEM.
- `busy`  out  1  an operation is in progress (state is not IDLE).
- `hi`  out  XLEN  HI register.
- `lo`  out  XLEN  LO register.
- `mf_result`  out  XLEN  MFHI/MFLO result for the EX/MEM latch.
- `mf_valid`  out  1  `mf_result` is valid this cycle.

## Operation
Op codes (`alu_op`):
- MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
- MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
- Any other code: ignored; contributes no stall.

Definitions:
- hilo_op = op_valid AND `alu_op` is one of the eight codes above.
- `stall` is combinational: stall = hilo_op AND (state != IDLE).

State machine (IDLE, CALC, FIX):
- IDLE → CALC on an accepted MULT/MULTU/DIV/DIVU (hilo_op and not stall). On acceptance:
  - latch operand magnitudes and result sign flags (signed ops only);
  - clear the counter and the 64-bit accumulator.
- CALC: one iteration per cycle. Counter increments 0 to 31; when the counter is 31, go to FIX.
- FIX: apply sign correction, write HI/LO, go to IDLE.

Arithmetic:
- Multiply: shift-add on magnitudes.
  - Result 64-bit; HI = upper XLEN bits, LO = lower XLEN bits.
  - Signed product is negated (two's complement, 64-bit) when the operand signs differ.
- Divide: restoring algorithm on magnitudes.
  - LO = quotient, HI = remainder.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
- Divide by zero (detected at acceptance): at FIX, LO = 32'hFFFFFFFF and HI = rs_data as captured. Latency is unchanged.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0. No trap.

MTHI/MTLO:
- In IDLE and not stall: write `rs_data` to HI or LO at the next edge.
- While busy: stall.

MFHI/MFLO:
- In IDLE: mf_valid = 1 and mf_result = HI or LO, combinationally in the same cycle.
- Otherwise mf_valid = 0 and mf_result = 0.

## Timing
Reset values, applied asynchronously:
- state = IDLE, counter = 0, hi = 0, lo = 0, accumulator = 0.
- busy = 0, stall = 0, mf_valid = 0, mf_result = 0.

Mult/div latency:
- Accepted at edge N.
- CALC during cycles N+1 to N+32; FIX in cycle N+33; HI/LO updated at the end of N+33.
- IDLE and new HI/LO visible from cycle N+34. busy is high for exactly 33 cycles.

Non-blocking behaviour:
- The issuing instruction itself is not stalled.
- Unrelated instructions flow through while busy.

Boundary conditions:
- Dependent op (MF*/MT*/another mult/div) in EX while busy, including during FIX: stall stays high until the cycle in which state is IDLE, then the op is accepted in that cycle.
- op_valid = 0 with a hilo `alu_op`: no effect, no stall.
- rst mid-operation: the operation is aborted and HI/LO are cleared. A later MFLO returns 0.

## Structure
- Shared package/header `alu_op_defs`: the eight op-code constants and `XLEN`. The ID-stage control decoder uses the same constants.
- Sub-module `md_iter_core`:
  - contains the shift-add / restore-subtract datapath and the 64-bit accumulator;
  - one iteration step per enable.
- The top level holds the FSM, counter, sign fix-up, HI/LO registers and the stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at cycle N+34: hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 0x00000005, busy high 33 cycles. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MULTU 6 × 7 at N, then MFLO held in EX from N+1:
  - stall high N+1 to N+33;
  - mf_valid = 1, mf_result = 42 at N+34.
- MULTU 3 × 4 at N, then unrelated ADD ops (alu_op 6'h20) during N+1 to N+33 → stall never asserted.
- MULTU at N, rst pulsed at N+10 → busy, stall, hi and lo are 0 immediately. A subsequent MFLO returns 0 with no stall.
